// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker for the traffic-light controller's
// lamp and seven-segment outputs.  It decodes the displays back to
// numbers, tracks the phase sequence and raises sticky error flags
// with a saturating event counter.
//
// Optional feature macro: TLMON_TIME_CHECK_EN (phase duration checking).
// When undefined, the phase timer is compiled out and err_time stays 0.
//
// Ports:
//   clk30M, Reset         clock, synchronous active-high reset
//   sec_tick              one-cycle strobe per second
//   clr_err               clears sticky flags and err_cnt
//   LR1..LG2              lamp states (1 = lit)
//   HEX0..HEX3            active-low segments g..a; HEX1:HEX0 = dir 1,
//                         HEX3:HEX2 = dir 2 (tens:units)
//   phase, locked         tracked phase (0..3) and sync indication
//   cnt1, cnt2            decoded display values (127 = pair blank)
//   err_conflict, err_seq, err_seg, err_time   sticky error flags
//   err_cnt               saturating count of cycles with an error event
module traffic_monitor #(
  parameter int G1_S  = 40,
  parameter int Y1_S  = 5,
  parameter int G2_S  = 30,
  parameter int Y2_S  = 5,
  parameter int TOL_S = 1
) (
  input  logic       clk30M,
  input  logic       Reset,
  input  logic       sec_tick,
  input  logic       clr_err,
  input  logic       LR1,
  input  logic       LY1,
  input  logic       LG1,
  input  logic       LR2,
  input  logic       LY2,
  input  logic       LG2,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX3,
  output logic [1:0] phase,
  output logic       locked,
  output logic [6:0] cnt1,
  output logic [6:0] cnt2,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       err_seg,
  output logic       err_time,
  output logic [7:0] err_cnt
);

  typedef enum logic {UNSYNC, TRACK} state_t;

  state_t     r_state;
  logic [5:0] r_lamps;
  logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3;
  logic [1:0] r_phase;
  logic       r_locked;
  logic [6:0] r_cnt1, r_cnt2;
  logic       r_err_conflict, r_err_seq, r_err_seg, r_err_time;
  logic [7:0] r_err_cnt;

  // Returns {bad, blank, digit[3:0]} for one active-low segment code.
  function automatic logic [5:0] seg_decode(input logic [6:0] code);
    case (code)
      7'h40:   return 6'd0;
      7'h79:   return 6'd1;
      7'h24:   return 6'd2;
      7'h30:   return 6'd3;
      7'h19:   return 6'd4;
      7'h12:   return 6'd5;
      7'h02:   return 6'd6;
      7'h78:   return 6'd7;
      7'h00:   return 6'd8;
      7'h10:   return 6'd9;
      7'h7F:   return 6'b01_0000;
      default: return 6'b10_0000;
    endcase
  endfunction

  // Returns {err, value[6:0]} for a tens:units pair. A pair must be either
  // fully blank (value 127) or two valid digits; anything else is an error.
  function automatic logic [7:0] pair_decode(input logic [6:0] tens,
                                             input logic [6:0] units);
    logic [5:0] t;
    logic [5:0] u;
    t = seg_decode(tens);
    u = seg_decode(units);
    if (t[5] || u[5])      return {1'b1, 7'h7F};
    else if (t[4] && u[4]) return {1'b0, 7'h7F};
    else if (t[4] || u[4]) return {1'b1, 7'h7F};
    else                   return {1'b0, 7'(t[3:0]) * 7'd10 + 7'(u[3:0])};
  endfunction

  logic       w_legal;
  logic [1:0] w_lphase;

  always_comb begin
    w_legal  = 1'b1;
    w_lphase = '0;
    case (r_lamps)
      6'b001100: w_lphase = 2'd0;
      6'b010100: w_lphase = 2'd1;
      6'b100001: w_lphase = 2'd2;
      6'b100010: w_lphase = 2'd3;
      default:   w_legal  = 1'b0;
    endcase
  end

  logic       w_track, w_hold, w_adv;
  logic       w_ev_conflict, w_ev_seq, w_ev_seg, w_ev_time, w_any_ev;
  logic [7:0] w_p1, w_p2;

  assign w_track       = (r_state == TRACK);
  assign w_hold        = w_track && w_legal && (w_lphase == r_phase);
  assign w_adv         = w_track && w_legal && (w_lphase == r_phase + 2'd1);
  assign w_ev_conflict = w_track && !w_legal;
  assign w_ev_seq      = w_track && w_legal && !w_hold && !w_adv;
  assign w_p1          = pair_decode(r_hex1, r_hex0);
  assign w_p2          = pair_decode(r_hex3, r_hex2);
  assign w_ev_seg      = w_p1[7] || w_p2[7];

`ifdef TLMON_TIME_CHECK_EN
  logic [6:0] r_timer;
  logic       r_chk;     // current phase was entered from a full-phase transition
  logic [6:0] w_req, w_lim, w_absdiff;

  always_comb begin
    case (r_phase)
      2'd0:    w_req = 7'(G1_S);
      2'd1:    w_req = 7'(Y1_S);
      2'd2:    w_req = 7'(G2_S);
      default: w_req = 7'(Y2_S);
    endcase
    w_lim     = w_req + 7'(TOL_S);
    w_absdiff = (r_timer >= w_req) ? (r_timer - w_req) : (w_req - r_timer);
  end

  // Stuck detection fires on the tick that takes the timer from
  // required+TOL to required+TOL+1, so it is raised once per phase.
  assign w_ev_time = r_chk &&
                     ((w_adv && (w_absdiff > 7'(TOL_S))) ||
                      (w_hold && sec_tick && (r_timer == w_lim)));
`else
  logic w_unused_time_cfg;
  assign w_unused_time_cfg = ^{G1_S, Y1_S, G2_S, Y2_S, TOL_S, sec_tick};
  assign w_ev_time = 1'b0;
`endif

  assign w_any_ev = w_ev_conflict || w_ev_seq || w_ev_seg || w_ev_time;

  always_ff @(posedge clk30M) begin
    if (Reset) begin
      r_state        <= UNSYNC;
      r_lamps        <= '0;
      r_hex0         <= '1;
      r_hex1         <= '1;
      r_hex2         <= '1;
      r_hex3         <= '1;
      r_phase        <= '0;
      r_locked       <= 1'b0;
      r_cnt1         <= '1;
      r_cnt2         <= '1;
      r_err_conflict <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_seg      <= 1'b0;
      r_err_time     <= 1'b0;
      r_err_cnt      <= '0;
`ifdef TLMON_TIME_CHECK_EN
      r_timer        <= '0;
      r_chk          <= 1'b0;
`endif
    end else begin
      r_lamps <= {LR1, LY1, LG1, LR2, LY2, LG2};
      r_hex0  <= HEX0;
      r_hex1  <= HEX1;
      r_hex2  <= HEX2;
      r_hex3  <= HEX3;

      case (r_state)
        UNSYNC: begin
          if (w_legal) begin
            r_state  <= TRACK;
            r_locked <= 1'b1;
            r_phase  <= w_lphase;
          end
        end
        TRACK: begin
          if (w_legal && !w_hold) r_phase <= w_lphase;
        end
        default: r_state <= UNSYNC;
      endcase

`ifdef TLMON_TIME_CHECK_EN
      if (w_legal && !w_hold) begin
        r_timer <= '0;
        r_chk   <= w_track;
      end else if (w_hold && sec_tick && (r_timer != '1)) begin
        r_timer <= r_timer + 7'd1;
      end
`endif

      if (!w_p1[7]) r_cnt1 <= w_p1[6:0];
      if (!w_p2[7]) r_cnt2 <= w_p2[6:0];

      // A new event in the clearing cycle survives the clear.
      r_err_conflict <= (r_err_conflict && !clr_err) || w_ev_conflict;
      r_err_seq      <= (r_err_seq      && !clr_err) || w_ev_seq;
      r_err_seg      <= (r_err_seg      && !clr_err) || w_ev_seg;
      r_err_time     <= (r_err_time     && !clr_err) || w_ev_time;
      if (clr_err)
        r_err_cnt <= {7'b0, w_any_ev};
      else if (w_any_ev && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign phase        = r_phase;
  assign locked       = r_locked;
  assign cnt1         = r_cnt1;
  assign cnt2         = r_cnt2;
  assign err_conflict = r_err_conflict;
  assign err_seq      = r_err_seq;
  assign err_seg      = r_err_seg;
  assign err_time     = r_err_time;
  assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor. Expectations are queued with
// the cycle at which they must hold; DUT outputs are snapshotted every
// cycle and each test task compares its queued expectations.
module tb_traffic_monitor;

  logic       clk30M = 1'b0;
  logic       Reset, sec_tick, clr_err;
  logic       LR1, LY1, LG1, LR2, LY2, LG2;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic [1:0] phase;
  logic       locked;
  logic [6:0] cnt1, cnt2;
  logic       err_conflict, err_seq, err_seg, err_time;
  logic [7:0] err_cnt;

  traffic_monitor #(.G1_S(40), .Y1_S(5), .G2_S(30), .Y2_S(5), .TOL_S(1)) dut (
    .clk30M(clk30M), .Reset(Reset), .sec_tick(sec_tick), .clr_err(clr_err),
    .LR1(LR1), .LY1(LY1), .LG1(LG1), .LR2(LR2), .LY2(LY2), .LG2(LG2),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .phase(phase), .locked(locked), .cnt1(cnt1), .cnt2(cnt2),
    .err_conflict(err_conflict), .err_seq(err_seq), .err_seg(err_seg),
    .err_time(err_time), .err_cnt(err_cnt)
  );

  always #5 clk30M = ~clk30M;

  localparam logic [5:0] P0 = 6'b001100, P1 = 6'b010100,
                         P2 = 6'b100001, P3 = 6'b100010, CONFV = 6'b001001;
  localparam int K_PHASE = 0, K_LOCKED = 1, K_CNT1 = 2, K_CNT2 = 3, K_CONF = 4,
                 K_SEQ = 5, K_SEG = 6, K_TIME = 7, K_ERRCNT = 8;
`ifdef TLMON_TIME_CHECK_EN
  localparam int TIME_EN = 1;
`else
  localparam int TIME_EN = 0;
`endif

  typedef struct packed {
    logic [1:0] phase;
    logic       locked;
    logic [6:0] cnt1;
    logic [6:0] cnt2;
    logic       conf, seq, seg, tim;
    logic [7:0] ecnt;
  } snap_t;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  snap_t      hist [4096];
  exp_t       sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(negedge clk30M)
    hist[cyc % 4096] <= {phase, locked, cnt1, cnt2, err_conflict, err_seq,
                         err_seg, err_time, err_cnt};

  function automatic logic [31:0] obs_of(input snap_t s, input int k);
    case (k)
      K_PHASE:  return 32'(s.phase);
      K_LOCKED: return 32'(s.locked);
      K_CNT1:   return 32'(s.cnt1);
      K_CNT2:   return 32'(s.cnt2);
      K_CONF:   return 32'(s.conf);
      K_SEQ:    return 32'(s.seq);
      K_SEG:    return 32'(s.seg);
      K_TIME:   return 32'(s.tim);
      default:  return 32'(s.ecnt);
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_PHASE:  return "phase";
      K_LOCKED: return "locked";
      K_CNT1:   return "cnt1";
      K_CNT2:   return "cnt2";
      K_CONF:   return "err_conflict";
      K_SEQ:    return "err_seq";
      K_SEG:    return "err_seg";
      K_TIME:   return "err_time";
      default:  return "err_cnt";
    endcase
  endfunction

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk30M);
      #1;
      cyc++;
    end
  endtask

  task automatic push(input int due, input int kind, input int val);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = 32'(val);
    sb.push_back(e);
  endtask

  task automatic set_lamps(input logic [5:0] v);
    {LR1, LY1, LG1, LR2, LY2, LG2} = v;
  endtask

  task automatic set_disp(input int a, input int b);
    HEX1 = seg_tab[a / 10];
    HEX0 = seg_tab[a % 10];
    HEX3 = seg_tab[b / 10];
    HEX2 = seg_tab[b % 10];
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1;
    adv(1);
    sec_tick = 1'b0;
  endtask

  // Enter a phase and hold it for 'secs' ticks, none coinciding with the change.
  task automatic run_phase(input logic [5:0] v, input int secs, input int ph);
    set_lamps(v);
    push(cyc + 2, K_PHASE, ph);
    adv(3);
    for (int i = 0; i < secs; i++) begin
      set_disp(secs - i, secs - i);
      pulse_tick();
      adv(1);
    end
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    adv(1);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] got;
    Reset = 1'b1;
    adv(2);
    Reset = 1'b0;
    push(cyc, K_PHASE, 0);
    push(cyc, K_LOCKED, 0);
    push(cyc, K_CNT1, 127);
    push(cyc, K_CNT2, 127);
    push(cyc, K_CONF, 0);
    push(cyc, K_SEQ, 0);
    push(cyc, K_SEG, 0);
    push(cyc, K_TIME, 0);
    push(cyc, K_ERRCNT, 0);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL reset/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_full_cycle();
    exp_t e;
    logic [31:0] got;
    int d;
    d = cyc;
    set_lamps(P0);
    push(d + 1, K_LOCKED, 0);
    push(d + 2, K_LOCKED, 1);
    push(d + 2, K_PHASE, 0);
    adv(3);
    repeat (3) begin
      pulse_tick();
      adv(1);
    end
    run_phase(P1, 5, 1);
    run_phase(P2, 30, 2);
    run_phase(P3, 5, 3);
    run_phase(P0, 40, 0);
    run_phase(P1, 5, 1);
    push(cyc, K_CONF, 0);
    push(cyc, K_SEQ, 0);
    push(cyc, K_SEG, 0);
    push(cyc, K_TIME, 0);
    push(cyc, K_ERRCNT, 0);
    push(cyc, K_CNT1, 1);
    push(cyc, K_CNT2, 1);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL cycle/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    logic [31:0] got;
    int c;
    c = cyc;
    set_lamps(CONFV);
    adv(1);
    set_lamps(P1);
    push(c + 1, K_CONF, 0);
    push(c + 2, K_CONF, 1);
    push(c + 2, K_ERRCNT, 1);
    push(c + 2, K_PHASE, 1);
    push(c + 2, K_LOCKED, 1);
    push(c + 3, K_ERRCNT, 1);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL conflict/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    logic [31:0] got;
    int c;
    c = cyc;
    clear_errors();
    push(c + 1, K_CONF, 0);
    push(c + 1, K_ERRCNT, 0);
    c = cyc;
    set_lamps(CONFV);
    adv(2);
    set_lamps(P1);
    push(c + 3, K_ERRCNT, 2);
    adv(3);
    // conflict event lands in the same cycle as clr_err
    c = cyc;
    set_lamps(CONFV);
    adv(1);
    clr_err = 1'b1;
    set_lamps(P1);
    adv(1);
    clr_err = 1'b0;
    push(c + 2, K_CONF, 1);
    push(c + 2, K_ERRCNT, 1);
    push(c + 3, K_ERRCNT, 1);
    adv(2);
    c = cyc;
    clear_errors();
    push(c + 1, K_CONF, 0);
    push(c + 1, K_ERRCNT, 0);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL clear/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_seq();
    exp_t e;
    logic [31:0] got;
    int c;
    run_phase(P2, 30, 2);
    run_phase(P3, 5, 3);
    run_phase(P0, 40, 0);
    c = cyc;
    set_lamps(P2);
    push(c + 1, K_SEQ, 0);
    push(c + 2, K_SEQ, 1);
    push(c + 2, K_PHASE, 2);
    push(c + 2, K_ERRCNT, 1);
    push(c + 3, K_ERRCNT, 1);
    adv(3);
    repeat (30) begin
      pulse_tick();
      adv(1);
    end
    run_phase(P3, 5, 3);
    run_phase(P0, 40, 0);
    push(cyc, K_ERRCNT, 1);
    push(cyc, K_CONF, 0);
    push(cyc, K_TIME, 0);
    c = cyc;
    clear_errors();
    push(c + 1, K_SEQ, 0);
    push(c + 1, K_ERRCNT, 0);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL seq/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_seg();
    exp_t e;
    logic [31:0] got;
    int c;
    c = cyc;
    HEX1 = seg_tab[3];
    HEX0 = seg_tab[5];
    HEX3 = seg_tab[9];
    HEX2 = seg_tab[0];
    push(c + 2, K_CNT1, 35);
    push(c + 2, K_CNT2, 90);
    push(c + 2, K_SEG, 0);
    adv(2);
    c = cyc;
    HEX0 = 7'h7E;
    push(c + 1, K_SEG, 0);
    push(c + 2, K_SEG, 1);
    push(c + 2, K_CNT1, 35);
    adv(2);
    c = cyc;
    HEX1 = 7'h7F;
    HEX0 = 7'h7F;
    push(c + 2, K_CNT1, 127);
    push(c + 2, K_ERRCNT, 2);
    push(c + 4, K_ERRCNT, 2);
    push(c + 4, K_CNT2, 90);
    adv(4);
    c = cyc;
    clear_errors();
    push(c + 1, K_SEG, 0);
    // blank tens with a valid units digit
    c = cyc;
    HEX0 = seg_tab[5];
    push(c + 2, K_SEG, 1);
    push(c + 2, K_CNT1, 127);
    adv(2);
    set_disp(0, 0);
    adv(3);
    c = cyc;
    clear_errors();
    push(c + 1, K_SEG, 0);
    push(c + 1, K_ERRCNT, 0);
    push(c + 1, K_CNT1, 0);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL seg/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_time();
    exp_t e;
    logic [31:0] got;
    int c;
    run_phase(P1, 5, 1);
    run_phase(P2, 30, 2);
    run_phase(P3, 5, 3);
    set_lamps(P0);
    push(cyc + 2, K_PHASE, 0);
    adv(3);
    for (int i = 1; i <= 43; i++) begin
      set_disp(44 - i, 44 - i);
      if (i == 42) begin
        push(cyc, K_TIME, 0);
        push(cyc + 1, K_TIME, TIME_EN);
        push(cyc + 1, K_ERRCNT, TIME_EN);
      end
      pulse_tick();
      adv(1);
    end
    run_phase(P1, 5, 1);
    push(cyc, K_TIME, TIME_EN);
    push(cyc, K_ERRCNT, 2 * TIME_EN);
    c = cyc;
    clear_errors();
    push(c + 1, K_TIME, 0);
    run_phase(P2, 30, 2);
    run_phase(P3, 5, 3);
    run_phase(P0, 41, 0);
    run_phase(P1, 5, 1);
    push(cyc, K_TIME, 0);
    push(cyc, K_ERRCNT, 0);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL time/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] got;
    int c;
    c = cyc;
    Reset = 1'b1;
    adv(1);
    Reset = 1'b0;
    push(c + 1, K_LOCKED, 0);
    push(c + 1, K_PHASE, 0);
    push(c + 1, K_CNT1, 127);
    push(c + 2, K_LOCKED, 0);
    push(c + 3, K_LOCKED, 1);
    push(c + 3, K_PHASE, 1);
    push(c + 3, K_ERRCNT, 0);
    while (sb.size() > 0) begin
      if (sb[0].due >= cyc) adv(1);
      else begin
        e = sb.pop_front();
        got = obs_of(hist[e.due % 4096], e.kind);
        checks++;
        if (got !== e.exp) begin
          failures++;
          $display("FAIL reset_mid/%s cyc=%0d got=%0d exp=%0d", kname(e.kind), e.due, got, e.exp);
        end
      end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    sec_tick = 1'b0;
    clr_err  = 1'b0;
    set_lamps(6'b000000);
    HEX0 = 7'h7F;
    HEX1 = 7'h7F;
    HEX2 = 7'h7F;
    HEX3 = 7'h7F;
    test_reset();
    test_full_cycle();
    test_conflict();
    test_clear();
    test_seq();
    test_seg();
    test_time();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Passive checker that observes the traffic-light controller's lamp outputs and four seven-segment digit buses, decodes the displays back to numbers, and flags illegal lamp combinations, out-of-order phases, bad segment codes and wrong phase durations. It is the receiving end of the controller's lamp/display interface: it sits beside the controller in the top level (or in the bench) and drives only status outputs. All error flags are sticky and counted.

## Interface

Parameters:
- G1_S, 40: required duration of phase G1R2, seconds
- Y1_S, 5: required duration of phase Y1R2, seconds
- G2_S, 30: required duration of phase R1G2, seconds
- Y2_S, 5: required duration of phase R1Y2, seconds
- TOL_S, 1: allowed ± deviation on any phase duration, seconds

Ports:
- clk30M  in  1  system clock; one clock; reset is synchronous and active-high
- Reset  in  1  synchronous active-high reset
- sec_tick  in  1  one-cycle strobe, once per second
- clr_err  in  1  clears sticky flags and err_cnt
- LR1, LY1, LG1, LR2, LY2, LG2  in  1 each  lamp states, 1 = lit
- HEX0..HEX3  in  7 each  active-low segments g..a; HEX1:HEX0 = direction 1 tens:units, HEX3:HEX2 = direction 2
- phase  out  2  0 = G1R2, 1 = Y1R2, 2 = R1G2, 3 = R1Y2
- locked  out  1  monitor has synchronised to the phase sequence
- cnt1, cnt2  out  7 each  decoded display values 0..99; 127 when both digits of that pair are blank
- err_conflict, err_seq, err_seg, err_time  out  1 each  sticky error flags
- err_cnt  out  8  saturating count of error events

## Operation

- Stage 1 registers all lamp and HEX inputs. All logic below acts on registered values.
- Lamp decode: legal vectors {LR1,LY1,LG1,LR2,LY2,LG2} = 001100 (G1R2), 010100 (Y1R2), 100001 (R1G2), 100010 (R1Y2). Any other vector is a conflict.
- FSM states: UNSYNC, TRACK.
  - UNSYNC: on the first legal vector, load phase and go to TRACK; locked = 1. The duration of this first partial phase is not checked.
  - TRACK, legal vector equal to phase: hold.
  - TRACK, legal vector equal to (phase+1) mod 4: advance; run the duration check on the exiting phase.
  - TRACK, any other legal vector: set err_seq, load the new phase, skip the duration check on the exiting phase.
  - TRACK, illegal vector: set err_conflict, stay in TRACK, keep phase and timer frozen.
- Seven-segment decode: codes 0..9 in standard active-low form (0 = 7'h40 … 9 = 7'h10); 7'h7F = blank. Any other code sets err_seg. A pair with one blank and one digit, or tens digit with blank units, also sets err_seg; cnt shows 127 for a fully blank pair, otherwise tens*10+units, holding the previous value on a bad code.
- Phase timer (7-bit, saturating at 127): cleared on every phase load, incremented on sec_tick while in TRACK.
- err_cnt increments by 1 per cycle in which at least one flag-setting event occurs (not per flag); saturates at 255.
- clr_err clears all four flags and err_cnt; an event in the same cycle wins (flag set, err_cnt = 1).

## Timing

- Reset values: phase = 0, locked = 0, cnt1 = cnt2 = 127, all err_* = 0, err_cnt = 0, timer = 0, FSM = UNSYNC.
- Latency: input change at edge N → registered at N+1 → phase/cnt/flags updated at N+2.
- sec_tick coinciding with a phase change: timer loads 0 (the tick is credited to neither phase).
- Reset asserted mid-operation overrides everything on that edge; the monitor resynchronises from UNSYNC.

## Configuration

- TLMON_TIME_CHECK_EN defined: duration check active. On an in-order exit, err_time is set if |timer − required| > TOL_S. While in a phase, err_time is also set once when timer reaches required + TOL_S + 1 (stuck lamps), without waiting for exit.
- Not defined: phase timer and comparators are omitted; err_time is tied to 0; all other behaviour unchanged.

## Test plan

- Reset, then a full legal cycle 40/5/30/5 s with correct displays → locked = 1 after first legal vector, phase steps 0→1→2→3→0, all flags 0, err_cnt = 0.
- Drive lamps 001001 (both green) for one cycle → err_conflict = 1 two cycles later, err_cnt = 1, phase unchanged.
- From G1R2 jump directly to R1G2 → err_seq = 1, phase = 2; next in-order transitions raise no new error.
- HEX1:HEX0 = 7'h30, 7'h12 (3,5) → cnt1 = 35; then HEX0 = 7'h7E → err_seg = 1, cnt1 stays 35; both 7'h7F → cnt1 = 127, no error.
- With TLMON_TIME_CHECK_EN: G1R2 held 43 s → err_time set at tick 42; G1R2 of 41 s → no error; without the macro, err_time stays 0.
- Assert clr_err after errors → all flags and err_cnt = 0 next cycle; clr_err coincident with a conflict → flag 1, err_cnt = 1.
